decode_seq: RTL and testbench

Parametrised micro-op sequencing decoder, the successor to the fixed three-slot decoder.
- Accepts one 32-bit fetch word over a valid/ready handshake and looks up its micro-op list.
- Issues the list one micro-op per accepted beat, each as a register-load code plus an ALU-input select code, to the execute stage.
- Reports the EIP increment with the last micro-op and traps unknown opcodes instead of driving X.
- Sits between fetch and the ALU/register-file control.

---
 rtl/decode_pkg.sv | 58 +++++
 rtl/decode_rom.sv | 94 +++++++++
 rtl/decode_seq.sv | 100 ++++++++++
 tb/tb_decode_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared constants and types for the micro-op sequencing decoder:
// register/select codes, opcode and modrm constants, and the micro-op record.
package decode_pkg;

  localparam int CODE_W = 4;
  localparam int ROM_STEPS = 3;  // longest list in the table

  localparam logic [CODE_W-1:0] REG_ESP = 4'd1;
  localparam logic [CODE_W-1:0] REG_EBP = 4'd2;
  localparam logic [CODE_W-1:0] REG_EAX = 4'd3;
  localparam logic [CODE_W-1:0] REG_EIP = 4'd4;
  localparam logic [CODE_W-1:0] REG_STK = 4'd5;
  localparam logic [CODE_W-1:0] REG_EDI = 4'd6;

  localparam logic [CODE_W-1:0] SEL_ESP = 4'd1;
  localparam logic [CODE_W-1:0] SEL_EBP = 4'd2;
  localparam logic [CODE_W-1:0] SEL_EAX = 4'd3;
  localparam logic [CODE_W-1:0] SEL_EIP = 4'd4;
  localparam logic [CODE_W-1:0] SEL_STK = 4'd5;
  localparam logic [CODE_W-1:0] SEL_EDI = 4'd6;
  localparam logic [CODE_W-1:0] SEL_IMM = 4'd7;

  localparam logic [7:0] OP_PUSH_EBP = 8'h55;
  localparam logic [7:0] OP_PUSH_EBX = 8'h53;
  localparam logic [7:0] OP_POP_EBP  = 8'h5d;
  localparam logic [7:0] OP_RET      = 8'hc3;
  localparam logic [7:0] OP_CALL     = 8'he8;
  localparam logic [7:0] OP_PUSH_I8  = 8'h6a;
  localparam logic [7:0] OP_LEAVE    = 8'hc9;
  localparam logic [7:0] OP_MOV_EAX  = 8'hb8;
  localparam logic [7:0] OP_MOV_RM   = 8'h89;
  localparam logic [7:0] OP_MOV_R    = 8'h8b;
  localparam logic [7:0] OP_GRP1     = 8'h83;
  localparam logic [7:0] OP_JNZ      = 8'h75;
  localparam logic [7:0] OP_JMP      = 8'heb;

  localparam logic [7:0] RM_E5 = 8'he5;
  localparam logic [7:0] RM_C3 = 8'hc3;
  localparam logic [7:0] RM_45 = 8'h45;
  localparam logic [7:0] RM_5D = 8'h5d;
  localparam logic [7:0] RM_EC = 8'hec;
  localparam logic [7:0] RM_C4 = 8'hc4;
  localparam logic [7:0] RM_E8 = 8'he8;
  localparam logic [7:0] RM_7D = 8'h7d;

  typedef struct packed {
    logic [CODE_W-1:0] load;
    logic [CODE_W-1:0] select;
  } uop_t;

  function automatic uop_t mk_uop(logic [CODE_W-1:0] l, logic [CODE_W-1:0] s);
    uop_t u;
    u.load   = l;
    u.select = s;
    return u;
  endfunction

endpackage

// File: rtl/decode_rom.sv
// Combinational micro-op table: maps a latched opcode/modrm pair to its step
// list, saturated instruction length and an illegal flag.
module decode_rom
  import decode_pkg::*;
#(
  parameter int MAX_STEPS = 4,
  parameter int LEN_W     = 4,
  localparam int CNT_W    = $clog2(MAX_STEPS + 1)
) (
  input  logic [15:0]      i_op,
  output logic [CNT_W-1:0] o_n_steps,
  output logic [LEN_W-1:0] o_len,
  output uop_t             o_steps [MAX_STEPS],
  output logic             o_illegal
);

  logic [7:0] w_raw_n;
  logic [7:0] w_raw_len;
  logic       w_unknown;
  uop_t       w_u [ROM_STEPS];

  always_comb begin
    w_raw_n   = 8'd0;
    w_raw_len = 8'd0;
    w_unknown = 1'b0;
    for (int i = 0; i < ROM_STEPS; i++) w_u[i] = '0;
    case (i_op[15:8])
      OP_PUSH_EBP: begin w_raw_n = 8'd2; w_raw_len = 8'd1;
        w_u[0] = mk_uop(REG_ESP, SEL_EBP); w_u[1] = mk_uop(REG_ESP, SEL_ESP); end
      OP_PUSH_EBX: begin w_raw_n = 8'd2; w_raw_len = 8'd1;
        w_u[0] = mk_uop(REG_ESP, SEL_EBP); w_u[1] = mk_uop(REG_ESP, SEL_IMM); end
      OP_POP_EBP: begin w_raw_n = 8'd2; w_raw_len = 8'd1;
        w_u[0] = mk_uop(REG_EBP, SEL_EIP); w_u[1] = mk_uop(REG_EBP, SEL_EBP); end
      OP_RET: begin w_raw_n = 8'd2; w_raw_len = 8'd1;
        w_u[0] = mk_uop(REG_EIP, SEL_EIP); w_u[1] = mk_uop(REG_EBP, SEL_EBP); end
      OP_CALL: begin w_raw_n = 8'd3; w_raw_len = 8'd5;
        w_u[0] = mk_uop(REG_ESP, SEL_EBP); w_u[1] = mk_uop(REG_ESP, SEL_EAX);
        w_u[2] = mk_uop(REG_EIP, SEL_EBP); end
      OP_PUSH_I8: begin w_raw_n = 8'd2; w_raw_len = 8'd2;
        w_u[0] = mk_uop(REG_ESP, SEL_EBP); w_u[1] = mk_uop(REG_ESP, SEL_EIP); end
      OP_LEAVE: begin w_raw_n = 8'd3; w_raw_len = 8'd1;
        w_u[0] = mk_uop(REG_ESP, SEL_STK); w_u[1] = mk_uop(REG_STK, SEL_STK);
        w_u[2] = mk_uop(REG_EBP, SEL_ESP); end
      OP_MOV_EAX: begin w_raw_n = 8'd1; w_raw_len = 8'd5;
        w_u[0] = mk_uop(REG_EAX, SEL_EAX); end
      OP_JNZ, OP_JMP: begin w_raw_n = 8'd1; w_raw_len = 8'd2;
        w_u[0] = mk_uop(REG_EIP, SEL_IMM); end
      OP_MOV_RM: begin
        w_raw_n = 8'd1; w_raw_len = 8'd2;
        case (i_op[7:0])
          RM_E5:   w_u[0] = mk_uop(REG_EBP, SEL_EBP);
          RM_C3:   w_u[0] = mk_uop(REG_EBP, SEL_EDI);
          default: w_unknown = 1'b1;
        endcase
      end
      OP_MOV_R: begin
        w_raw_n = 8'd2; w_raw_len = 8'd3;
        w_u[0] = mk_uop(REG_STK, SEL_STK);
        case (i_op[7:0])
          RM_45:   w_u[1] = mk_uop(REG_EAX, SEL_EDI);
          RM_5D:   w_u[1] = mk_uop(REG_STK, SEL_EDI);
          default: w_unknown = 1'b1;
        endcase
      end
      OP_GRP1: begin
        w_raw_n = 8'd1; w_raw_len = 8'd3;
        case (i_op[7:0])
          RM_EC, RM_C4: w_u[0] = mk_uop(REG_ESP, SEL_EBP);
          RM_E8:        w_u[0] = mk_uop(REG_EAX, SEL_EDI);
          RM_7D: begin
            w_raw_n = 8'd2; w_raw_len = 8'd4;
            w_u[0] = mk_uop(REG_STK, SEL_STK); w_u[1] = mk_uop(REG_EDI, SEL_EDI);
          end
          default: w_unknown = 1'b1;
        endcase
      end
      default: w_unknown = 1'b1;
    endcase
  end

  for (genvar g = 0; g < MAX_STEPS; g++) begin : g_steps
    if (g < ROM_STEPS) begin : g_tab
      assign o_steps[g] = w_u[g];
    end else begin : g_pad
      assign o_steps[g] = '0;
    end
  end

  // Lengths that do not fit LEN_W saturate instead of wrapping.
  assign o_len     = (32'(w_raw_len) > (2 ** LEN_W) - 1) ? '1 : LEN_W'(w_raw_len);
  assign o_n_steps = CNT_W'(w_raw_n);
  assign o_illegal = w_unknown || (32'(w_raw_n) > MAX_STEPS);

endmodule

// File: rtl/decode_seq.sv
// Micro-op sequencer: accepts a fetch word, then issues its micro-op list one
// beat per accepted handshake, or traps until acknowledged if undecodable.
module decode_seq
  import decode_pkg::*;
#(
  parameter int MAX_STEPS = 4,
  parameter int SEL_W     = 4,
  parameter int LEN_W     = 4,
  localparam int STEP_W   = $clog2(MAX_STEPS)
) (
  input  logic              clk2,
  input  logic              reset,
  input  logic [31:0]       ope,
  input  logic              ope_valid,
  output logic              ope_ready,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [SEL_W-1:0]  uop_load,
  output logic [SEL_W-1:0]  uop_select,
  output logic [STEP_W-1:0] uop_step,
  output logic              uop_last,
  output logic [LEN_W-1:0]  eip_inc,
  output logic              illegal,
  input  logic              illegal_ack,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(MAX_STEPS + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_TRAP  = 2'd2;

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // the sender holds its payload stable until that edge.
  logic [1:0]        r_state;
  logic [15:0]       r_op;
  logic [STEP_W-1:0] r_step;

  logic [15:0]       w_rom_op;
  logic [CNT_W-1:0]  w_n_steps;
  logic [LEN_W-1:0]  w_len;
  uop_t              w_steps [MAX_STEPS];
  logic              w_rom_illegal;
  logic              w_issue;
  logic              w_last;
  logic              w_accept;
  logic              w_unused;
  uop_t              w_cur;

  // In IDLE the ROM looks at the incoming word so legality is known at accept.
  assign w_rom_op = (r_state == ST_IDLE) ? ope[31:16] : r_op;
  assign w_unused = ^ope[15:0];

  decode_rom #(.MAX_STEPS(MAX_STEPS), .LEN_W(LEN_W)) u_rom (
    .i_op      (w_rom_op),
    .o_n_steps (w_n_steps),
    .o_len     (w_len),
    .o_steps   (w_steps),
    .o_illegal (w_rom_illegal)
  );

  assign w_issue  = (r_state == ST_ISSUE);
  assign w_accept = (r_state == ST_IDLE) && ope_valid;
  assign w_last   = w_issue && (CNT_W'(r_step) == w_n_steps - CNT_W'(1));
  assign w_cur    = w_steps[r_step];

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_step  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op    <= ope[31:16];
          r_step  <= '0;
          r_state <= w_rom_illegal ? ST_TRAP : ST_ISSUE;
        end
        ST_ISSUE: if (uop_ready) begin
          if (w_last) r_state <= ST_IDLE;
          else        r_step  <= r_step + 1'b1;
        end
        ST_TRAP: if (illegal_ack) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ope_ready  = (r_state == ST_IDLE);
  assign uop_valid  = w_issue;
  assign illegal    = (r_state == ST_TRAP);
  assign uop_last   = w_last;
  assign uop_load   = w_issue ? SEL_W'(w_cur.load)   : '0;
  assign uop_select = w_issue ? SEL_W'(w_cur.select) : '0;
  assign uop_step   = w_issue ? r_step : '0;
  assign eip_inc    = w_last  ? w_len  : '0;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_decode_seq.sv
// Directed bench for decode_seq: table of every opcode plus illegal words,
// then hand-written stall, back-to-back, trap and mid-sequence reset cases.
module tb_decode_seq;

  logic        clk2 = 1'b0;
  logic        reset;
  logic [31:0] ope;
  logic        ope_valid;
  logic        ope_ready;
  logic        uop_valid;
  logic        uop_ready;
  logic [3:0]  uop_load;
  logic [3:0]  uop_select;
  logic [1:0]  uop_step;
  logic        uop_last;
  logic [3:0]  eip_inc;
  logic        illegal;
  logic        illegal_ack;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  decode_seq #(.MAX_STEPS(4), .SEL_W(4), .LEN_W(4)) dut (
    .clk2(clk2), .reset(reset), .ope(ope), .ope_valid(ope_valid),
    .ope_ready(ope_ready), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_load(uop_load), .uop_select(uop_select), .uop_step(uop_step),
    .uop_last(uop_last), .eip_inc(eip_inc), .illegal(illegal),
    .illegal_ack(illegal_ack), .dbg_state(dbg_state)
  );

  always #5 clk2 = ~clk2;

  typedef struct {
    logic [15:0]      op;
    bit               modrm;  // modrm byte is part of the decode
    int               n;      // 0 = illegal
    logic [2:0][3:0]  ld;
    logic [2:0][3:0]  sl;
    logic [3:0]       len;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [15:0] op, bit m, int n,
                              logic [3:0] l0, logic [3:0] s0, logic [3:0] l1,
                              logic [3:0] s1, logic [3:0] l2, logic [3:0] s2,
                              logic [3:0] len);
    vec_t v;
    v.op = op; v.modrm = m; v.n = n; v.len = len;
    v.ld = {l2, l1, l0};
    v.sl = {s2, s1, s0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_beat(input vec_t v, input int b);
    chk("uop_valid", 32'(uop_valid), 1);
    chk("uop_load", 32'(uop_load), 32'(v.ld[b]));
    chk("uop_select", 32'(uop_select), 32'(v.sl[b]));
    chk("uop_step", 32'(uop_step), b);
    chk("uop_last", 32'(uop_last), 32'(b == v.n - 1));
    chk("eip_inc", 32'(eip_inc), (b == v.n - 1) ? 32'(v.len) : 0);
    chk("ope_ready_busy", 32'(ope_ready), 0);
  endtask

  task automatic chk_idle();
    chk("idle_ready", 32'(ope_ready), 1);
    chk("idle_valid", 32'(uop_valid), 0);
    chk("idle_illegal", 32'(illegal), 0);
    chk("idle_codes", {uop_load, uop_select, uop_step, eip_inc, 3'b0, uop_last}, 0);
  endtask

  function automatic logic [31:0] word_of(vec_t v);
    logic [7:0] m;
    m = v.modrm ? v.op[7:0] : 8'($urandom_range(0, 255));
    return {v.op[15:8], m, 16'($urandom_range(0, 65535))};
  endfunction

  // Present one word from idle, accept it, and walk its beats with uop_ready=1.
  task automatic run_vec(input vec_t v);
    @(negedge clk2);
    ope = word_of(v); ope_valid = 1'b1; uop_ready = 1'b1;
    chk("accept_ready", 32'(ope_ready), 1);
    @(negedge clk2);
    ope_valid = 1'b0;
    ope = 32'h0f00_0000;
    if (v.n == 0) begin
      chk("trap_illegal", 32'(illegal), 1);
      chk("trap_valid", 32'(uop_valid), 0);
      chk("trap_ready", 32'(ope_ready), 0);
      illegal_ack = 1'b1;
      @(negedge clk2);
      illegal_ack = 1'b0;
    end else begin
      for (int b = 0; b < v.n; b++) begin
        chk_beat(v, b);
        @(negedge clk2);
      end
    end
    chk_idle();
  endtask

  initial begin
    vec_t e8v, b8v, m8b, c9v;
    bit pat[5];
    int b;

    reset = 1'b1; ope = '0; ope_valid = 1'b0; uop_ready = 1'b1; illegal_ack = 1'b0;

    vecs.push_back(mk(16'h5500, 0, 2, 1, 2, 1, 1, 0, 0, 1));
    vecs.push_back(mk(16'h5300, 0, 2, 1, 2, 1, 7, 0, 0, 1));
    vecs.push_back(mk(16'h5d00, 0, 2, 2, 4, 2, 2, 0, 0, 1));
    vecs.push_back(mk(16'hc300, 0, 2, 4, 4, 2, 2, 0, 0, 1));
    vecs.push_back(mk(16'he800, 0, 3, 1, 2, 1, 3, 4, 2, 5));
    vecs.push_back(mk(16'h6a00, 0, 2, 1, 2, 1, 4, 0, 0, 2));
    vecs.push_back(mk(16'hc900, 0, 3, 1, 5, 5, 5, 2, 1, 1));
    vecs.push_back(mk(16'hb800, 0, 1, 3, 3, 0, 0, 0, 0, 5));
    vecs.push_back(mk(16'h89e5, 1, 1, 2, 2, 0, 0, 0, 0, 2));
    vecs.push_back(mk(16'h89c3, 1, 1, 2, 6, 0, 0, 0, 0, 2));
    vecs.push_back(mk(16'h8b45, 1, 2, 5, 5, 3, 6, 0, 0, 3));
    vecs.push_back(mk(16'h8b5d, 1, 2, 5, 5, 5, 6, 0, 0, 3));
    vecs.push_back(mk(16'h83ec, 1, 1, 1, 2, 0, 0, 0, 0, 3));
    vecs.push_back(mk(16'h83c4, 1, 1, 1, 2, 0, 0, 0, 0, 3));
    vecs.push_back(mk(16'h83e8, 1, 1, 3, 6, 0, 0, 0, 0, 3));
    vecs.push_back(mk(16'h837d, 1, 2, 5, 5, 6, 6, 0, 0, 4));
    vecs.push_back(mk(16'h7500, 0, 1, 4, 7, 0, 0, 0, 0, 2));
    vecs.push_back(mk(16'heb00, 0, 1, 4, 7, 0, 0, 0, 0, 2));
    vecs.push_back(mk(16'h0f00, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h8900, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h8bc0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h8345, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hff00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    e8v = vecs[4]; c9v = vecs[6]; b8v = vecs[7]; m8b = vecs[10];

    repeat (3) @(negedge clk2);
    chk_idle();
    reset = 1'b0;
    @(negedge clk2);
    chk_idle();

    foreach (vecs[i]) run_vec(vecs[i]);

    // e8 with execute-stage stalls; ope garbage during issue must not matter.
    pat = '{1, 0, 0, 1, 1};
    @(negedge clk2);
    ope = word_of(e8v); ope_valid = 1'b1;
    @(negedge clk2);
    ope_valid = 1'b0;
    b = 0;
    for (int c = 0; c < 5; c++) begin
      ope = 32'($urandom);
      uop_ready = pat[c];
      chk_beat(e8v, b);
      @(negedge clk2);
      if (pat[c]) b++;
    end
    uop_ready = 1'b1;
    chk_idle();

    // Back-to-back: second word waits for the last beat of the first.
    ope = word_of(m8b); ope_valid = 1'b1;
    @(negedge clk2);
    ope = word_of(b8v);
    chk_beat(m8b, 0);
    @(negedge clk2);
    chk_beat(m8b, 1);
    @(negedge clk2);
    chk_idle();
    @(negedge clk2);
    ope_valid = 1'b0;
    chk_beat(b8v, 0);
    @(negedge clk2);
    chk_idle();

    // Trap holds until acknowledged; ack in idle is ignored.
    ope = 32'h0f00_0000; ope_valid = 1'b1;
    @(negedge clk2);
    ope_valid = 1'b0;
    repeat (2) begin
      chk("trap_hold", 32'(illegal), 1);
      chk("trap_no_valid", 32'(uop_valid), 0);
      @(negedge clk2);
    end
    illegal_ack = 1'b1;
    @(negedge clk2);
    chk_idle();
    @(negedge clk2);
    illegal_ack = 1'b0;
    chk("ack_in_idle", 32'(dbg_state), 0);
    chk_idle();

    // Reset during step 1 of c9, then c9 restarts from step 0.
    ope = word_of(c9v); ope_valid = 1'b1;
    @(negedge clk2);
    ope_valid = 1'b0;
    chk_beat(c9v, 0);
    @(negedge clk2);
    chk_beat(c9v, 1);
    #2 reset = 1'b1;
    #1;
    chk("reset_drop_valid", 32'(uop_valid), 0);
    chk_idle();
    @(negedge clk2);
    reset = 1'b0;
    run_vec(c9v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
